// File: rtl/dds_freq_meter.sv
`timescale 1ns/1ps
// dds_freq_meter: iterative CORDIC (vectoring) phase recovery of quadrature samples plus an
// averaged phase-increment (FCW) estimate. Define DDS_FMETER_MAG_EN to add the mag_out port.
module dds_freq_meter #(
    parameter int DW       = 20,
    parameter int PW       = 32,
    parameter int ITER     = 16,
    parameter int AVG_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] sin_in,
    input  logic signed [DW-1:0] cos_in,
    output logic [PW-1:0]        phase_out,
    output logic                 phase_vld,
    output logic [PW-1:0]        fcw_est,
    output logic                 fcw_vld
`ifdef DDS_FMETER_MAG_EN
    ,
    output logic [DW+1:0]        mag_out
`endif
);

    localparam int XW = DW + 2;
    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int AW = PW + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [IW-1:0] ITER_LAST = IW'(ITER - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(1 << AVG_LOG2);

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        DIFF
    } state_t;

    // Elaboration-time angle constant; a real-to-integer cast rounds to nearest.
    function automatic logic [PW-1:0] atan_const(input int i);
        real a;
        a = $atan(2.0 ** (-i)) * (2.0 ** PW) / (2.0 * 3.14159265358979323846);
        return PW'(longint'(a));
    endfunction

    logic [PW-1:0] atan_tab [2**IW];

    for (genvar g = 0; g < 2**IW; g++) begin : g_atan
        if (g < ITER) begin : g_used
            assign atan_tab[g] = atan_const(g);
        end else begin : g_pad
            assign atan_tab[g] = '0;
        end
    end

    state_t               state;
    logic signed [XW-1:0] x, y;
    logic signed [XW-1:0] x_sh, y_sh;
    logic signed [XW-1:0] cos_ext, sin_ext;
    logic [PW-1:0]        z;
    logic [IW-1:0]        iter;
    logic                 zero_q;
    logic                 accept;

    logic [PW-1:0]        prev;
    logic                 primed;
    logic [PW-1:0]        diff;
    logic [AW-1:0]        acc, acc_sum;
    logic [CW-1:0]        cnt, cnt_inc;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign cos_ext  = {{2{cos_in[DW-1]}}, cos_in};
    assign sin_ext  = {{2{sin_in[DW-1]}}, sin_in};
    assign x_sh     = x >>> iter;
    assign y_sh     = y >>> iter;

    // Modulo-2^PW difference makes phase wrap-through-zero transparent.
    assign diff     = z - prev;
    assign acc_sum  = acc + {{AVG_LOG2{1'b0}}, diff};
    assign cnt_inc  = cnt + CW'(1);

    // NOTE: the CORDIC datapath carries no reset; the FSM ignores it until a fresh load.
    always_ff @(posedge clk) begin
        if (accept) begin
            zero_q <= (sin_in == '0) && (cos_in == '0);
            iter   <= '0;
            if (cos_in[DW-1]) begin
                x <= -cos_ext;
                y <= -sin_ext;
                z <= {1'b1, {(PW-1){1'b0}}};
            end else begin
                x <= cos_ext;
                y <= sin_ext;
                z <= '0;
            end
        end else if (state == ROT) begin
            iter <= iter + IW'(1);
            if (y[XW-1]) begin
                x <= x - y_sh;
                y <= y + x_sh;
                z <= z - atan_tab[iter];
            end else begin
                x <= x + y_sh;
                y <= y - x_sh;
                z <= z + atan_tab[iter];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: strobes default low each cycle so any assertion below is a one-cycle pulse.
        phase_vld <= 1'b0;
        fcw_vld   <= 1'b0;
        if (!rst) begin
            state     <= IDLE;
            phase_out <= '0;
            fcw_est   <= '0;
            prev      <= '0;
            primed    <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) state <= ROT;
                end
                ROT: begin
                    if (iter == ITER_LAST) state <= DIFF;
                end
                DIFF: begin
                    state <= IDLE;
                    if (zero_q) begin
                        primed <= 1'b0;
                    end else begin
                        phase_out <= z;
                        phase_vld <= 1'b1;
                        prev      <= z;
                        primed    <= 1'b1;
                        if (primed) begin
                            if (cnt_inc == CNT_FULL) begin
                                fcw_est <= acc_sum[AW-1:AVG_LOG2];
                                fcw_vld <= 1'b1;
                                acc     <= '0;
                                cnt     <= '0;
                            end else begin
                                acc <= acc_sum;
                                cnt <= cnt_inc;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DDS_FMETER_MAG_EN
    // Final x is the unscaled vector magnitude (CORDIC gain ~1.6468).
    always_ff @(posedge clk) begin
        if (!rst) begin
            mag_out <= '0;
        end else if (state == DIFF) begin
            mag_out <= zero_q ? '0 : x;
        end
    end
`endif

endmodule

// File: tb/tb_dds_freq_meter.sv
`timescale 1ns/1ps
// Self-checking bench for dds_freq_meter: table vectors, hand-written corner sequences and
// randomized streams scored against an atan/average reference model.
module tb_dds_freq_meter;

    localparam int     DW       = 20;
    localparam int     PW       = 32;
    localparam int     ITER     = 16;
    localparam int     AVG_LOG2 = 4;
    localparam int     NAVG     = 1 << AVG_LOG2;
    localparam longint PH_TOL   = 64'd1 << (PW - ITER + 2);
    localparam longint FCW_TOL  = 64'd1 << 16;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] sin_in;
    logic signed [DW-1:0] cos_in;
    logic [PW-1:0]        phase_out;
    logic                 phase_vld;
    logic [PW-1:0]        fcw_est;
    logic                 fcw_vld;
`ifdef DDS_FMETER_MAG_EN
    logic [DW+1:0]        mag_out;
`endif

    dds_freq_meter #(.DW(DW), .PW(PW), .ITER(ITER), .AVG_LOG2(AVG_LOG2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sin_in    (sin_in),
        .cos_in    (cos_in),
        .phase_out (phase_out),
        .phase_vld (phase_vld),
        .fcw_est   (fcw_est),
        .fcw_vld   (fcw_vld)
`ifdef DDS_FMETER_MAG_EN
        ,
        .mag_out   (mag_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic bit near(input logic [31:0] a, input logic [31:0] e, input longint tol);
        logic signed [31:0] d;
        longint ad;
        d  = a - e;
        ad = d;
        if (ad < 0) ad = -ad;
        return ad <= tol;
    endfunction

    // Reference model: ideal phases, queue of modulo differences, average every NAVG.
    bit          m_primed;
    logic [31:0] m_prev;
    logic [31:0] m_diffs[$];

    function automatic void model_reset();
        m_primed = 1'b0;
        m_diffs.delete();
    endfunction

    function automatic void model_step(input bit zero, input logic [31:0] ph,
                                       output bit fv, output logic [31:0] fcw);
        longint s;
        fv  = 1'b0;
        fcw = '0;
        if (zero) begin
            m_primed = 1'b0;
            return;
        end
        if (m_primed) begin
            m_diffs.push_back(ph - m_prev);
            if (m_diffs.size() == NAVG) begin
                s = 0;
                foreach (m_diffs[k]) s += longint'(m_diffs[k]);
                fcw = 32'(s / NAVG);
                fv  = 1'b1;
                m_diffs.delete();
            end
        end
        m_prev   = ph;
        m_primed = 1'b1;
    endfunction

    function automatic void gen(input logic [31:0] ph, input int amp,
                                output logic signed [DW-1:0] c, output logic signed [DW-1:0] s);
        real a;
        int  ci, si;
        a  = 6.283185307179586 * real'(ph) / 4294967296.0;
        ci = int'(real'(amp) * $cos(a));
        si = int'(real'(amp) * $sin(a));
        c  = ci[DW-1:0];
        s  = si[DW-1:0];
    endfunction

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Push one sample and watch the result window; returns what the outputs did.
    task automatic run_sample(input logic signed [DW-1:0] c, input logic signed [DW-1:0] s,
                              output bit pv, output int lat, output logic [31:0] ph,
                              output bit fv, output logic [31:0] fe, output logic [DW+1:0] mg);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("in_ready_timeout", 1'b0, 0, 1);
        in_valid = 1'b1;
        cos_in   = c;
        sin_in   = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pv = 1'b0; fv = 1'b0; lat = 0; ph = '0; fe = '0;
        for (int k = 1; k <= ITER + 4; k++) begin
            @(posedge clk);
            #1;
            if (phase_vld && !pv) begin
                pv  = 1'b1;
                lat = k;
                ph  = phase_out;
            end
            if (fcw_vld) begin
                fv = 1'b1;
                fe = fcw_est;
            end
        end
`ifdef DDS_FMETER_MAG_EN
        mg = mag_out;
`else
        mg = '0;
`endif
    endtask

    task automatic do_sample_cs(input string tag, input bit zero,
                                input logic signed [DW-1:0] c, input logic signed [DW-1:0] s,
                                input logic [31:0] ideal, output bit fv_out);
        bit              pv, fv, efv;
        int              lat;
        logic [31:0]     ph, fe, efcw;
        logic [DW+1:0]   mg;
        run_sample(c, s, pv, lat, ph, fv, fe, mg);
        model_step(zero, ideal, efv, efcw);
        check({tag, " phase_vld"}, pv == !zero, longint'(pv), longint'(!zero));
        if (!zero && pv) begin
            check({tag, " latency"}, lat == ITER + 1, lat, ITER + 1);
            check({tag, " phase"}, near(ph, ideal, PH_TOL), ph, ideal);
        end
`ifdef DDS_FMETER_MAG_EN
        if (zero) check({tag, " mag_zero"}, mg == '0, mg, 0);
`endif
        check({tag, " fcw_vld"}, fv == efv, longint'(fv), longint'(efv));
        if (fv && efv) check({tag, " fcw_est"}, near(fe, efcw, FCW_TOL), fe, efcw);
        fv_out = fv;
    endtask

    task automatic do_sample(input string tag, input bit zero, input logic [31:0] ideal,
                             input int amp, output bit fv);
        logic signed [DW-1:0] c, s;
        if (zero) begin
            c = '0;
            s = '0;
        end else begin
            gen(ideal, amp, c, s);
        end
        do_sample_cs(tag, zero, c, s, ideal, fv);
    endtask

    task automatic stream(input string tag, input logic [31:0] fcw, input int n,
                          input int zero_at, output int first_fv);
        logic [31:0] ph;
        bit          fv;
        ph       = $urandom;
        first_fv = 0;
        for (int k = 1; k <= n; k++) begin
            if (k == zero_at) begin
                do_sample(tag, 1'b1, 32'h0, 0, fv);
            end else begin
                do_sample(tag, 1'b0, ph, int'($urandom_range(500000, 200000)), fv);
                ph += fcw;
            end
            if (fv && first_fv == 0) first_fv = k;
        end
    endtask

    typedef struct {
        logic signed [DW-1:0] c;
        logic signed [DW-1:0] s;
        logic [31:0]          ph;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int            first;
        int            pulses;
        bit            fv, pv, efv;
        int            lat;
        logic [31:0]   ph, fe, efcw, ph_a;
        logic [DW+1:0] mg;
        logic signed [DW-1:0] ca, sa, cb, sb;

        vecs[0] = '{c:  20'sd262144, s:  20'sd0,      ph: 32'h00000000};
        vecs[1] = '{c:  20'sd0,      s:  20'sd262144, ph: 32'h40000000};
        vecs[2] = '{c: -20'sd262144, s:  20'sd0,      ph: 32'h80000000};
        vecs[3] = '{c:  20'sd0,      s: -20'sd262144, ph: 32'hC0000000};
        vecs[4] = '{c:  20'sd262144, s:  20'sd262144, ph: 32'h20000000};
        vecs[5] = '{c: -20'sd262144, s:  20'sd262144, ph: 32'h60000000};
        vecs[6] = '{c: -20'sd262144, s: -20'sd262144, ph: 32'hA0000000};
        vecs[7] = '{c:  20'sd262144, s: -20'sd262144, ph: 32'hE0000000};

        // Reset held with in_valid asserted.
        rst      = 1'b0;
        in_valid = 1'b1;
        sin_in   = 20'sd1234;
        cos_in   = -20'sd5678;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", in_ready == 1'b1, in_ready, 1);
        check("rst phase_out", phase_out == '0, phase_out, 0);
        check("rst fcw_est", fcw_est == '0, fcw_est, 0);
        check("rst phase_vld", phase_vld == 1'b0, phase_vld, 0);
        check("rst fcw_vld", fcw_vld == 1'b0, fcw_vld, 0);
`ifdef DDS_FMETER_MAG_EN
        check("rst mag_out", mag_out == '0, mag_out, 0);
`endif
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("post_rst no_vld", !phase_vld && !fcw_vld, {phase_vld, fcw_vld}, 0);
        end
        model_reset();

        // Axes and diagonals.
        for (int i = 0; i < 8; i++) begin
            do_sample_cs($sformatf("vec%0d", i), 1'b0, vecs[i].c, vecs[i].s, vecs[i].ph, fv);
`ifdef DDS_FMETER_MAG_EN
            if (i == 0) begin
                mg = mag_out;
                check("mag (2^18,0)", (mg > 22'd431400) && (mg < 22'd432000), mg, 431700);
            end
`endif
        end

        // in_valid while busy is ignored: B must never be accepted.
        gen(32'h30000000, 262144, ca, sa);
        gen(32'hA0000000, 262144, cb, sb);
        @(negedge clk);
        in_valid = 1'b1;
        cos_in   = ca;
        sin_in   = sa;
        @(posedge clk);
        #1;
        cos_in = cb;
        sin_in = sb;
        pulses = 0;
        ph     = '0;
        repeat (5) @(posedge clk);
        #1;
        check("busy in_ready", in_ready == 1'b0, in_ready, 0);
        in_valid = 1'b0;
        for (int k = 6; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (phase_vld) begin
                pulses++;
                ph = phase_out;
            end
        end
        check("busy one_result", pulses == 1, pulses, 1);
        check("busy phase", near(ph, 32'h30000000, PH_TOL), ph, 32'h30000000);
        model_step(1'b0, 32'h30000000, efv, efcw);

        // Loopback-style stream, FCW 0x12345678.
        apply_reset(2);
        model_reset();
        stream("fcw1234", 32'h12345678, 20, 0, first);
        check("fcw1234 first_vld", first == NAVG + 1, first, NAVG + 1);

        // High FCW reads back modulo 2^PW.
        apply_reset(2);
        model_reset();
        stream("fcwF000", 32'hF0000000, 20, 0, first);
        check("fcwF000 first_vld", first == NAVG + 1, first, NAVG + 1);

        // Zero sample mid-stream delays the estimate by one valid sample.
        apply_reset(2);
        model_reset();
        stream("zero", 32'h0ABCDEF0, 22, 6, first);
        check("zero first_vld", first == NAVG + 3, first, NAVG + 3);

        // Reset five cycles into ROT aborts the sample and the accumulated estimate.
        apply_reset(2);
        model_reset();
        stream("pre_abort", 32'h2468ACE0, 5, 0, first);
        gen(32'h55555555, 300000, ca, sa);
        @(negedge clk);
        in_valid = 1'b1;
        cos_in   = ca;
        sin_in   = sa;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("abort in_ready", in_ready == 1'b1, in_ready, 1);
        check("abort fcw_est", fcw_est == '0, fcw_est, 0);
        check("abort phase_out", phase_out == '0, phase_out, 0);
        pulses = 0;
        repeat (ITER + 4) begin
            @(posedge clk);
            #1;
            if (phase_vld || fcw_vld) pulses++;
        end
        check("abort no_vld", pulses == 0, pulses, 0);
        model_reset();
        stream("post_abort", 32'h2468ACE0, 18, 0, first);
        check("post_abort first_vld", first == NAVG + 1, first, NAVG + 1);

        // Randomized streams with an occasional zero sample.
        for (int r = 0; r < 3; r++) begin
            apply_reset(1);
            model_reset();
            stream($sformatf("rand%0d", r), 32'($urandom_range(32'hFEFFFFFF, 32'h01000000)),
                   36, int'($urandom_range(30, 3)), first);
        end

        // Unused capture outputs from the direct run_sample path.
        run_sample(20'sd100000, 20'sd0, pv, lat, ph, fv, fe, mg);
        check("final latency", pv && lat == ITER + 1, lat, ITER + 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
